// File: rtl/cart_ram_uploader.sv
// cart_ram_uploader: serves hps_io upload byte requests from the cart/save RAM
// read port, stalling the HPS with ioctl_wait while the RAM read is in flight.
// Also counts bytes returned per session and tracks whether the RAM image has
// been modified since the last complete upload.
module cart_ram_uploader #(
    parameter int          AW     = 13,
    parameter int          RD_LAT = 1,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    input  logic [AW:0]   mem_size,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    input  logic          core_wr,
    output logic          dirty,
    output logic [AW:0]   bytes_sent,
    output logic          upload_done,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAT   = 2'd2
    } state_t;

    // Byte counter saturates at the full RAM size.
    localparam logic [AW:0] SENT_MAX = {1'b1, {AW{1'b0}}};
    // Counter value loaded on leaving FETCH; LAT completes when it reaches zero.
    localparam logic [1:0]  LAT_LOAD = 2'(RD_LAT - 1);

    state_t        state_r, state_s;
    logic [7:0]    din_r, din_s;
    logic          wait_r, wait_s;
    logic [AW-1:0] ram_addr_r, ram_addr_s;
    logic          ram_rd_r, ram_rd_s;
    logic          dirty_r, dirty_s;
    logic [AW:0]   sent_r, sent_s;
    logic          done_r, done_s;
    logic          perr_r, perr_s;
    logic [1:0]    cnt_r, cnt_s;
    logic          upload_q_r;

    logic          upload_rise_s;
    logic          upload_fall_s;
    logic          in_range_s;
    logic [AW:0]   sent_base_s;
    logic [AW:0]   sent_inc_s;

    // Session edge detection, range check and saturating byte-count increment.
    always_comb begin
        upload_rise_s = ioctl_upload & ~upload_q_r;
        upload_fall_s = ~ioctl_upload & upload_q_r;
        // Full 25-bit compare: any address bit at or above AW makes it out of range.
        in_range_s    = (ioctl_addr < 25'(mem_size));
        sent_base_s   = upload_rise_s ? {(AW+1){1'b0}} : sent_r;
        if (sent_base_s == SENT_MAX) begin
            sent_inc_s = SENT_MAX;
        end else begin
            sent_inc_s = sent_base_s + {{AW{1'b0}}, 1'b1};
        end
    end

    // Next-state and next-output logic for the request FSM and status flags.
    always_comb begin
        state_s    = state_r;
        din_s      = din_r;
        wait_s     = wait_r;
        ram_addr_s = ram_addr_r;
        ram_rd_s   = 1'b0;
        sent_s     = sent_base_s;
        cnt_s      = cnt_r;
        perr_s     = perr_r;
        done_s     = upload_fall_s;
        dirty_s    = dirty_r;

        case (state_r)
            IDLE: begin
                if (ioctl_upload && ioctl_rd) begin
                    if (in_range_s) begin
                        ram_addr_s = ioctl_addr[AW-1:0];
                        ram_rd_s   = 1'b1;
                        wait_s     = 1'b1;
                        state_s    = FETCH;
                    end else begin
                        // Out-of-range bytes are answered immediately without a stall.
                        din_s  = FILL;
                        sent_s = sent_inc_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (!ioctl_upload) begin
                    wait_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    cnt_s   = LAT_LOAD;
                    state_s = LAT;
                end
            end
            LAT: begin
                if (!ioctl_upload) begin
                    // Session aborted: drop the request without counting it.
                    wait_s  = 1'b0;
                    state_s = IDLE;
                end else if (cnt_r == 2'd0) begin
                    din_s   = ram_q;
                    wait_s  = 1'b0;
                    sent_s  = sent_inc_s;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 2'd1;
                end
            end
            default: begin
                wait_s  = 1'b0;
                state_s = IDLE;
            end
        endcase

        if ((state_r != IDLE) && ioctl_rd) begin
            perr_s = 1'b1;
        end else begin
            perr_s = perr_s;
        end

        // A core write always wins over the end-of-session clear.
        if (core_wr) begin
            dirty_s = 1'b1;
        end else if (upload_fall_s && (sent_r >= mem_size)) begin
            dirty_s = 1'b0;
        end else begin
            dirty_s = dirty_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            din_r      <= 8'h00;
            wait_r     <= 1'b0;
            ram_addr_r <= {AW{1'b0}};
            ram_rd_r   <= 1'b0;
            dirty_r    <= 1'b0;
            sent_r     <= {(AW+1){1'b0}};
            done_r     <= 1'b0;
            perr_r     <= 1'b0;
            cnt_r      <= 2'd0;
            upload_q_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            din_r      <= din_s;
            wait_r     <= wait_s;
            ram_addr_r <= ram_addr_s;
            ram_rd_r   <= ram_rd_s;
            dirty_r    <= dirty_s;
            sent_r     <= sent_s;
            done_r     <= done_s;
            perr_r     <= perr_s;
            cnt_r      <= cnt_s;
            upload_q_r <= ioctl_upload;
        end
    end

    assign ioctl_din   = din_r;
    assign ioctl_wait  = wait_r;
    assign ram_addr    = ram_addr_r;
    assign ram_rd      = ram_rd_r;
    assign dirty       = dirty_r;
    assign bytes_sent  = sent_r;
    assign upload_done = done_r;
    assign proto_err   = perr_r;

endmodule

// File: tb/tb_cart_ram_uploader.sv
// Directed bench for cart_ram_uploader: one instance with RAM latency 1 and one
// with latency 3, each backed by a small RAM model holding RAM[i] = i.
module tb_cart_ram_uploader;

    logic        clk;
    logic        rst_n;
    logic [13:0] mem_size;

    logic        upload1, rd1, core_wr1;
    logic [24:0] addr1;
    logic [7:0]  din1, q1;
    logic        wait1, rrd1, dirty1, done1, perr1;
    logic [12:0] raddr1;
    logic [13:0] sent1;

    logic        upload3, rd3;
    logic [24:0] addr3;
    logic [7:0]  din3, q3, p0, p1;
    logic        wait3, rrd3, dirty3, done3, perr3;
    logic [12:0] raddr3;
    logic [13:0] sent3;

    int checks   = 0;
    int failures = 0;
    logic [7:0] d;
    int n;

    cart_ram_uploader #(.AW(13), .RD_LAT(1), .FILL(8'hFF)) dut1 (
        .clk_sys(clk), .reset_n(rst_n), .ioctl_upload(upload1), .ioctl_rd(rd1),
        .ioctl_addr(addr1), .ioctl_din(din1), .ioctl_wait(wait1), .mem_size(mem_size),
        .ram_addr(raddr1), .ram_rd(rrd1), .ram_q(q1), .core_wr(core_wr1),
        .dirty(dirty1), .bytes_sent(sent1), .upload_done(done1), .proto_err(perr1)
    );

    cart_ram_uploader #(.AW(13), .RD_LAT(3), .FILL(8'hFF)) dut3 (
        .clk_sys(clk), .reset_n(rst_n), .ioctl_upload(upload3), .ioctl_rd(rd3),
        .ioctl_addr(addr3), .ioctl_din(din3), .ioctl_wait(wait3), .mem_size(mem_size),
        .ram_addr(raddr3), .ram_rd(rrd3), .ram_q(q3), .core_wr(1'b0),
        .dirty(dirty3), .bytes_sent(sent3), .upload_done(done3), .proto_err(perr3)
    );

    always #5 clk = ~clk;

    // RAM model, latency 1: RAM[i] = i.
    always @(posedge clk) begin
        if (rrd1) q1 <= raddr1[7:0];
    end

    // RAM model, latency 3.
    always @(posedge clk) begin
        if (rrd3) p0 <= raddr3[7:0];
        p1 <= p0;
        q3 <= p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; returns the byte and the number of sampled cycles wait was high.
    task automatic req(input bit sel, input logic [24:0] a, output logic [7:0] dout, output int cnt);
        if (sel) begin rd3 = 1'b1; addr3 = a; end
        else     begin rd1 = 1'b1; addr1 = a; end
        @(negedge clk);
        rd1 = 1'b0;
        rd3 = 1'b0;
        cnt = 0;
        while ((sel ? wait3 : wait1) && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        dout = sel ? din3 : din1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; mem_size = 14'd16;
        upload1 = 1'b0; rd1 = 1'b0; addr1 = 25'd0; core_wr1 = 1'b0;
        upload3 = 1'b0; rd3 = 1'b0; addr3 = 25'd0;
        repeat (2) @(negedge clk);
        chk("rst_din", 32'(din1), 32'h0);
        chk("rst_wait", 32'(wait1), 32'h0);
        chk("rst_ram_addr", 32'(raddr1), 32'h0);
        chk("rst_ram_rd", 32'(rrd1), 32'h0);
        chk("rst_dirty", 32'(dirty1), 32'h0);
        chk("rst_sent", 32'(sent1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_perr", 32'(perr1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scenario 1: 16 in-range bytes, latency 1.
        upload1 = 1'b1;
        @(negedge clk);
        chk("s1_sent_start", 32'(sent1), 32'h0);
        for (int i = 0; i < 16; i++) begin
            req(1'b0, 25'(i), d, n);
            chk("s1_din", 32'(d), 32'(i));
            chk("s1_wait_cycles", 32'(n), 32'd2);
        end
        chk("s1_sent", 32'(sent1), 32'd16);

        // Scenario 2: out-of-range requests.
        req(1'b0, 25'd20, d, n);
        chk("s2_fill", 32'(d), 32'hFF);
        chk("s2_no_wait", 32'(n), 32'd0);
        chk("s2_sent", 32'(sent1), 32'd17);
        mem_size = 14'd8192;
        req(1'b0, 25'h2003, d, n);
        chk("s2_high_bits_fill", 32'(d), 32'hFF);
        chk("s2_high_bits_no_wait", 32'(n), 32'd0);
        req(1'b0, 25'd5, d, n);
        chk("s2_full_size_din", 32'(d), 32'h05);
        mem_size = 14'd16;
        chk("s2_sent_total", 32'(sent1), 32'd19);

        // Scenario 3: dirty tracking around session end.
        upload1 = 1'b0;
        @(negedge clk);
        chk("s3_done_pulse0", 32'(done1), 32'h1);
        @(negedge clk);
        chk("s3_done_low0", 32'(done1), 32'h0);
        core_wr1 = 1'b1;
        @(negedge clk);
        core_wr1 = 1'b0;
        chk("s3_dirty_set", 32'(dirty1), 32'h1);
        upload1 = 1'b1;
        @(negedge clk);
        chk("s3_sent_cleared", 32'(sent1), 32'h0);
        for (int i = 0; i < 16; i++) req(1'b0, 25'(i), d, n);
        upload1 = 1'b0;
        @(negedge clk);
        chk("s3_done_full", 32'(done1), 32'h1);
        chk("s3_dirty_cleared", 32'(dirty1), 32'h0);
        @(negedge clk);
        chk("s3_done_one_cycle", 32'(done1), 32'h0);
        core_wr1 = 1'b1;
        @(negedge clk);
        core_wr1 = 1'b0;
        upload1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) req(1'b0, 25'(i), d, n);
        chk("s3_sent_partial", 32'(sent1), 32'd8);
        upload1 = 1'b0;
        @(negedge clk);
        chk("s3_done_partial", 32'(done1), 32'h1);
        chk("s3_dirty_kept", 32'(dirty1), 32'h1);
        @(negedge clk);

        // Scenario 4: request while busy.
        upload1 = 1'b1;
        @(negedge clk);
        rd1 = 1'b1; addr1 = 25'd3;
        @(negedge clk);
        chk("s4_wait_busy", 32'(wait1), 32'h1);
        rd1 = 1'b1; addr1 = 25'd7;
        @(negedge clk);
        rd1 = 1'b0;
        chk("s4_proto_err", 32'(perr1), 32'h1);
        n = 0;
        while (wait1 && n < 20) begin n++; @(negedge clk); end
        chk("s4_first_byte", 32'(din1), 32'h03);
        chk("s4_sent", 32'(sent1), 32'd1);
        @(negedge clk);
        chk("s4_ignored_no_wait", 32'(wait1), 32'h0);
        chk("s4_ignored_sent", 32'(sent1), 32'd1);

        // Scenario 5: upload dropped during LAT.
        rd1 = 1'b1; addr1 = 25'd9;
        @(negedge clk);
        rd1 = 1'b0;
        chk("s5_wait_fetch", 32'(wait1), 32'h1);
        @(negedge clk);
        upload1 = 1'b0;
        @(negedge clk);
        chk("s5_wait_abort", 32'(wait1), 32'h0);
        chk("s5_sent_unchanged", 32'(sent1), 32'd1);
        chk("s5_din_held", 32'(din1), 32'h03);
        chk("s5_done", 32'(done1), 32'h1);
        @(negedge clk);
        chk("s5_dirty_kept", 32'(dirty1), 32'h1);

        // Scenario 6: async reset mid-request, then latency-3 rerun.
        upload3 = 1'b1;
        @(negedge clk);
        rd3 = 1'b1; addr3 = 25'd4;
        @(negedge clk);
        rd3 = 1'b0;
        chk("s6_wait_pre", 32'(wait3), 32'h1);
        chk("s6_ram_rd_pre", 32'(rrd3), 32'h1);
        chk("s6_ram_addr_pre", 32'(raddr3), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_wait", 32'(wait3), 32'h0);
        chk("s6_async_ram_rd", 32'(rrd3), 32'h0);
        chk("s6_async_ram_addr", 32'(raddr3), 32'h0);
        chk("s6_async_perr", 32'(perr1), 32'h0);
        chk("s6_async_dirty", 32'(dirty1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 25'(i), d, n);
            chk("s6_din_lat3", 32'(d), 32'(i));
            chk("s6_wait_cycles_lat3", 32'(n), 32'd4);
        end
        chk("s6_sent_lat3", 32'(sent3), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
